fifo_wr_arbiter: RTL

Write-side controller for the FIFO memory. It arbitrates up to NUM_REQ requesters onto the single memory write port using round-robin with burst locking. It drives the memory write strobe, address and data, maintains the binary and Gray write pointers, and generates `full` from the read-domain Gray pointer after synchronising it. The block sits between the write-domain clients and the FIFO memory; the read-side controller consumes its `wr_ptr_gray`.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/ptr_sync_2ff.sv | 21 ++
 rtl/fifo_wr_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO widths, write-arbiter states and Gray helper
package fifo_pkg;
    localparam int FIFO_NUM_REQ    = 4;
    localparam int FIFO_DATA_WIDTH = 1;
    localparam int FIFO_ADDR_WIDTH = 3;
    localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;
    localparam int GRANT_ID_WIDTH  = 3;
    localparam int PTR_MAX_WIDTH   = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } wr_state_e;

    // Callers zero-extend into and truncate out of the fixed width.
    function automatic logic [PTR_MAX_WIDTH-1:0] bin2gray(input logic [PTR_MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction
endpackage

// File: rtl/ptr_sync_2ff.sv
// rtl/ptr_sync_2ff.sv - two-flop synchroniser for Gray-coded pointers
module ptr_sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst-locked write port arbiter with Gray pointers and full
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ       = FIFO_NUM_REQ,
    parameter int WR_DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int WR_ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int MEM_DEPTH     = FIFO_DEPTH
) (
    input  logic                             wr_clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_last,
    input  logic [NUM_REQ*WR_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [WR_ADDR_WIDTH:0]           rd_ptr_gray,
    output logic                             wr_en,
    output logic [WR_ADDR_WIDTH-1:0]         wr_addr,
    output logic [WR_DATA_WIDTH-1:0]         wr_data,
    output logic [WR_ADDR_WIDTH:0]           wr_ptr_gray,
    output logic                             full,
    output logic                             grant_valid,
    output logic [GRANT_ID_WIDTH-1:0]        grant_id
);
    localparam int A  = WR_ADDR_WIDTH;
    localparam int PW = WR_ADDR_WIDTH + 1;

    if (MEM_DEPTH != (1 << WR_ADDR_WIDTH)) begin : g_depth_check
        $error("MEM_DEPTH must equal 2**WR_ADDR_WIDTH");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_req_check
        $error("NUM_REQ must be in 2..8");
    end

    wr_state_e                 state, state_next;
    logic [2:0]                gnt, last_gnt, pick;
    logic [3:0]                cand;
    logic [7:0]                valid_ext, last_ext;
    logic [WR_DATA_WIDTH-1:0]  data_arr [8];
    logic [PW-1:0]             wr_ptr_bin, wr_ptr_bin_next, wr_ptr_gray_next;
    logic [PW-1:0]             rd_sync, full_match;
    logic                      any_valid, accept, release_gnt;

    ptr_sync_2ff #(.WIDTH(PW)) u_rd_sync (
        .clk   (wr_clk),
        .reset (reset),
        .d     (rd_ptr_gray),
        .q     (rd_sync)
    );

    // Widen per-requester vectors to 8 so a 3-bit grant index always fits.
    assign valid_ext = 8'(req_valid);
    assign last_ext  = 8'(req_last);
    assign any_valid = |req_valid;

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_data
        if (gi < NUM_REQ) begin : g_used
            assign data_arr[gi] = req_data[gi*WR_DATA_WIDTH +: WR_DATA_WIDTH];
        end else begin : g_unused
            assign data_arr[gi] = '0;
        end
    end

    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = (state == GRANT) && (gnt == 3'(gi)) && !full;
    end

    assign accept      = (state == GRANT) && valid_ext[gnt] && !full;
    assign release_gnt = (state == GRANT) && (!valid_ext[gnt] || (accept && last_ext[gnt]));

    // Scan from farthest to nearest so the nearest valid requester after last_gnt wins.
    always_comb begin
        pick = last_gnt;
        cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = {1'b0, last_gnt} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (valid_ext[cand[2:0]]) begin
                pick = cand[2:0];
            end
        end
    end

    assign wr_ptr_bin_next  = wr_ptr_bin + PW'(accept);
    assign wr_ptr_gray_next = PW'(bin2gray(PTR_MAX_WIDTH'(wr_ptr_bin_next)));
    assign full_match       = {~rd_sync[A:A-1], rd_sync[A-2:0]};

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_valid)   state_next = GRANT;
            GRANT:   if (release_gnt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_valid = (state == GRANT);
        grant_id    = gnt;
    end

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            gnt      <= '0;
            last_gnt <= 3'(NUM_REQ - 1);
        end else begin
            if (state == IDLE && any_valid) begin
                gnt <= pick;
            end
            if (release_gnt) begin
                last_gnt <= gnt;
            end
        end
    end

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_ptr_bin  <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr     <= wr_ptr_bin[A-1:0];
                wr_data     <= data_arr[gnt];
                wr_ptr_bin  <= wr_ptr_bin_next;
                wr_ptr_gray <= wr_ptr_gray_next;
            end
            full <= (wr_ptr_gray_next == full_match);
        end
    end
endmodule
